// File: rtl/bnn_layer_scheduler.sv
// Layer/neuron sequencer for the binary neuron engine: issues one engine job per output
// neuron and writes the returned sign bit into the ping-pong activation RAM.
module bnn_layer_scheduler #(
  parameter int NUM_LAYERS = 4,
  parameter int CNT_W      = 11,
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_layer,
  input  logic [CNT_W-1:0]      cfg_n_in,
  input  logic [CNT_W-1:0]      cfg_n_out,
  output logic                  eng_start,
  output logic [W_ADDR_LEN-1:0] eng_w_base,
  output logic [CNT_W-1:0]      eng_n_in,
  output logic                  eng_x_bank,
  input  logic                  eng_done,
  input  logic                  eng_result,
  output logic                  act_we,
  output logic                  act_bank,
  output logic [X_ADDR_LEN-1:0] act_addr,
  output logic                  act_wdata,
  output logic [1:0]            layer_idx,
  output logic [2:0]            state_dbg
);

  // Handshake: eng_start is a single-cycle job request; the job's operands stay stable
  // until the activation write completes. eng_done is only honoured while waiting.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cfg_n_in_q  [NUM_LAYERS];
  logic [CNT_W-1:0]      cfg_n_out_q [NUM_LAYERS];
  logic [1:0]            layer_q;
  logic [CNT_W-1:0]      neuron_q;
  logic [W_ADDR_LEN-1:0] w_base_q;
  logic                  res_q;

  logic [CNT_W-1:0]      cur_n_in;
  logic [CNT_W-1:0]      cur_n_out;
  logic [CNT_W-1:0]      neuron_nxt;
  logic                  more_neurons;
  logic                  last_layer;
  logic                  eng_active;

  assign cur_n_in     = cfg_n_in_q[layer_q];
  assign cur_n_out    = cfg_n_out_q[layer_q];
  assign neuron_nxt   = neuron_q + CNT_W'(1);
  assign more_neurons = (neuron_nxt < cur_n_out);
  assign last_layer   = (layer_q == 2'(NUM_LAYERS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: state_d = (cur_n_out == '0) ? S_FIN : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (eng_done) state_d = S_WRITE;
      S_WRITE: begin
        if (more_neurons)    state_d = S_ISSUE;
        else if (last_layer) state_d = S_FIN;
        else                 state_d = S_CHECK;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Config table is writable only while idle so a running schedule never changes shape.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        cfg_n_in_q[i]  <= '0;
        cfg_n_out_q[i] <= '0;
      end
    end else if (state_q == S_IDLE && cfg_we) begin
      cfg_n_in_q[cfg_layer]  <= cfg_n_in;
      cfg_n_out_q[cfg_layer] <= cfg_n_out;
    end
  end

  // Weights are packed back to back across layers, so w_base only restarts on a new run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_q  <= '0;
      neuron_q <= '0;
      w_base_q <= '0;
      res_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            layer_q  <= '0;
            neuron_q <= '0;
            w_base_q <= '0;
          end
        end
        S_WAIT: begin
          if (eng_done) res_q <= eng_result;
        end
        S_WRITE: begin
          w_base_q <= w_base_q + W_ADDR_LEN'(cur_n_in);
          if (more_neurons) begin
            neuron_q <= neuron_nxt;
          end else if (!last_layer) begin
            layer_q  <= layer_q + 2'd1;
            neuron_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign eng_active = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_WRITE);

  always_comb begin
    busy       = (state_q == S_CHECK) || eng_active;
    done       = (state_q == S_FIN);
    eng_start  = (state_q == S_ISSUE);
    eng_w_base = eng_active ? w_base_q : '0;
    eng_n_in   = eng_active ? cur_n_in : '0;
    eng_x_bank = eng_active & layer_q[0];
    act_we     = (state_q == S_WRITE);
    act_bank   = act_we & ~layer_q[0];
    act_addr   = act_we ? neuron_q[X_ADDR_LEN-1:0] : '0;
    act_wdata  = act_we & res_q;
    layer_idx  = layer_q;
    state_dbg  = state_q;
  end

endmodule
